pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central flush/stall sequencer for the 5-stage pipeline. Takes jump/branch
//  resolution and hazard flags from ID/EX/MEM, drives PC select/enable, IF/ID and
//  ID/EX enables, and the per-register flush strobes (rst_ir of IF/ID, ID/EX regs,
//  including the jal/jalr pipeline register). Multi-cycle flush windows via small FSM.
// PARAMETERS
//  FLUSH_CYC_EX  2   flush cycles for an EX-resolved redirect (jalr / taken branch), 1..15
//  CNT_W         16  width of performance counters (HAZ_PERF_EN only)
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst          in   1      synchronous, active-high reset
//  jal_id       in   1      jal decoded in ID stage
//  jalr_ex      in   1      jalr resolved in EX stage
//  br_taken_ex  in   1      conditional branch resolved taken in EX
//  ld_use_id    in   1      load-use hazard detected on ID instruction
//  mem_busy     in   1      data memory not ready; pipeline must freeze
//  pc_sel       out  2      00 PC+4, 01 jal target (ID), 10 jalr/branch target (EX)
//  pc_en        out  1      PC register write enable
//  ifid_en      out  1      IF/ID register write enable
//  idex_en      out  1      ID/EX (and later) register enable
//  flush_ifid   out  1      clears IF/ID regs (drives rst_ir)
//  flush_idex   out  1      clears ID/EX regs (inserts bubble)
//  flush_cnt    out  CNT_W  redirect events counted (HAZ_PERF_EN)
//  stall_cnt    out  CNT_W  stall cycles counted (HAZ_PERF_EN)
// BEHAVIOUR
//  - States: RUN, FLUSH. 4-bit down-counter cnt. Outputs combinational from state+inputs.
//  - Reset (rst=1 on edge): state<=RUN, cnt<=0. While rst high: pc_sel=00, pc_en=0,
//    ifid_en=0, idex_en=0, flush_ifid=1, flush_idex=1. Counters <=0.
//  - Default (RUN, no event): pc_sel=00, all enables 1, flushes 0.
//  - Priority each cycle: mem_busy > EX redirect > jal_id > ld_use_id.
//  - mem_busy=1 (any state): pc_en=ifid_en=idex_en=0, flushes 0, pc_sel=00; state
//    and cnt hold. Pending EX/ID events are re-evaluated when mem_busy drops.
//  - RUN, ex_redir=jalr_ex|br_taken_ex: pc_sel=10, flush_ifid=1, flush_idex=1, enables 1.
//    If FLUSH_CYC_EX>1: state<=FLUSH, cnt<=FLUSH_CYC_EX-1; else stay RUN.
//  - FLUSH: pc_sel=00, enables 1, flush_ifid=1, flush_idex=1; all redirect/hazard
//    inputs ignored (squashed instrs). cnt decrements; cnt==1 -> RUN next cycle.
//  - RUN, jal_id (no ex_redir): pc_sel=01, flush_ifid=1 for exactly one cycle, no state change.
//  - RUN, ld_use_id only: pc_en=0, ifid_en=0, flush_idex=1, idex_en=1; one bubble
//    per cycle ld_use_id is high.
//  - jal_id + ld_use_id together: jal wins; ld_use ignored (instruction consumed).
//  - Reset mid-FLUSH aborts window: RUN next cycle, cnt=0.
// CONFIGURATION
//  HAZ_PERF_EN defined: flush_cnt +1 per accepted redirect (EX in RUN, or jal_id in RUN),
//    stall_cnt +1 per cycle with pc_en=0 and rst=0; both saturate at all-ones.
//  HAZ_PERF_EN undefined: counters not built, flush_cnt/stall_cnt tied to 0.
// TESTING
//  1 rst high 3 cycles, release -> flushes 1/enables 0 during rst; cycle after: RUN defaults, pc_sel=00.
//  2 jalr_ex pulse 1 cycle (FLUSH_CYC_EX=2) -> pc_sel=10 that cycle; flush_ifid/idex=1 for 2 cycles; RUN on 3rd.
//  3 jal_id pulse -> pc_sel=01, flush_ifid=1 one cycle, flush_idex=0; ld_use_id same cycle ignored.
//  4 ld_use_id 2 cycles -> pc_en=ifid_en=0, flush_idex=1 both cycles; resumes when low.
//  5 br_taken_ex with mem_busy=1 for 3 cycles -> all enables 0, no flush; redirect on cycle 4.
//  6 HAZ_PERF_EN: 3 redirects + 2 ld_use cycles -> flush_cnt=3, stall_cnt=2; preload saturation holds all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: flush/stall sequencer for the 5-stage pipeline.
// Resolves redirect and hazard requests into PC select/enable, pipeline
// register enables and per-register flush strobes. An EX-resolved redirect
// opens a multi-cycle flush window tracked by a small RUN/FLUSH FSM.
// Optional build macro: HAZ_PERF_EN adds saturating redirect/stall counters;
// without it flush_cnt/stall_cnt are tied to zero.
//
// state | meaning
// RUN   | normal issue; redirects and hazards are acted on
// FLUSH | squash window after an EX redirect; all requests ignored
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYC_EX = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jal_id,
    input  logic             jalr_ex,
    input  logic             br_taken_ex,
    input  logic             ld_use_id,
    input  logic             mem_busy,
    output logic [1:0]       pc_sel,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC_EX - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       ex_redir;

    assign ex_redir = jalr_ex | br_taken_ex;

    // Output decode from state and inputs; priority rst > mem_busy > EX > jal > ld_use.
    always_comb begin
        pc_sel     = 2'b00;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (mem_busy) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
        end else if (state == FLUSH) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (ex_redir) begin
            pc_sel     = 2'b10;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (jal_id) begin
            // jal consumes the ID instruction, so a coincident load-use is moot
            pc_sel     = 2'b01;
            flush_ifid = 1'b1;
        end else if (ld_use_id) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            flush_idex = 1'b1;
        end
    end

    // FSM and flush-window down-counter; everything freezes while memory is busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else if (!mem_busy) begin
            case (state)
                RUN: begin
                    if (ex_redir && (FLUSH_CYC_EX > 1)) begin
                        state <= FLUSH;
                        cnt   <= FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    // <= 1 rather than == 1 so a corrupted cnt can never strand the FSM
                    if (cnt <= 4'd1) begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_EN
    logic redir_acc;
    logic stall_cyc;

    assign redir_acc = !rst && !mem_busy && (state == RUN) && (ex_redir || jal_id);
    assign stall_cyc = !rst && !pc_en;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (redir_acc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
            if (stall_cyc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign flush_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
